// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Scoreboard entries carry a fixed-width rd field, so REG_AW must not exceed RD_MAX_W.
package pipe_pkg;

    localparam int RD_MAX_W = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                vld;
        logic [RD_MAX_W-1:0] rd;
        logic                we;
        logic                ld;
    } sb_entry_t;

    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_sel_enc.sv
// Priority encoder: the youngest in-flight slot that can forward to one source operand,
// plus a flag for a matching load that is still too young to forward.
module hazard_sel_enc
    import pipe_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int LOAD_SLOT = 2,
    parameter int SEL_W     = 2
) (
    input  logic [RD_MAX_W-1:0]        src,
    input  logic                       use_src,
    input  logic [STAGES-1:0]          vld,
    input  logic [STAGES-1:0]          we,
    input  logic [STAGES-1:0]          ld,
    input  logic [STAGES*RD_MAX_W-1:0] rd,
    output logic [SEL_W-1:0]           sel,
    output logic                       load_hazard
);

    logic [STAGES-1:0] match_s;
    logic [STAGES-1:0] qual_s;
    logic [STAGES-1:0] young_ld_s;

    // Per-slot match; index 0 is hard-wired and never matches.
    always_comb begin
        match_s    = {STAGES{1'b0}};
        qual_s     = {STAGES{1'b0}};
        young_ld_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            match_s[k]    = use_src && (src != {RD_MAX_W{1'b0}}) && vld[k] && we[k]
                            && (rd[k*RD_MAX_W +: RD_MAX_W] == src);
            qual_s[k]     = match_s[k] && (!ld[k] || ((k + 1) >= LOAD_SLOT));
            young_ld_s[k] = match_s[k] && ld[k] && ((k + 1) < LOAD_SLOT);
        end
    end

    // Scan oldest to youngest so the lowest qualifying slot is the one that sticks.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        for (int k = STAGES - 1; k >= 0; k--) begin
            sel = qual_s[k] ? SEL_W'(k + 1) : sel;
        end
        load_hazard = |young_ld_s;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard controller beside decode: destination scoreboard, operand forwarding selects,
// load-use stall, taken-branch flush and saturating stall/flush event counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int STAGES    = 3,
    parameter int LOAD_SLOT = 2,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rs1,
    input  logic [REG_AW-1:0]             id_rs2,
    input  logic                          id_use_rs1,
    input  logic                          id_use_rs2,
    input  logic [REG_AW-1:0]             id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_isload,
    input  logic                          ex_branch_taken,
    output logic                          stall,
    output logic                          flush,
    output logic [sel_width(STAGES)-1:0]  fwd_a_sel,
    output logic [sel_width(STAGES)-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int               SEL_W   = sel_width(STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    sb_entry_t                  sb_r [1:STAGES];
    logic [STAGES-1:0]          sb_vld_s;
    logic [STAGES-1:0]          sb_we_s;
    logic [STAGES-1:0]          sb_ld_s;
    logic [STAGES*RD_MAX_W-1:0] sb_rd_s;
    logic [SEL_W-1:0]           sel_a_s;
    logic [SEL_W-1:0]           sel_b_s;
    logic                       haz_a_s;
    logic                       haz_b_s;
    logic                       flush_s;
    logic                       stall_s;
    logic [CNT_W-1:0]           stall_cnt_r;
    logic [CNT_W-1:0]           flush_cnt_r;

    // Flatten the scoreboard into per-field vectors for the encoders.
    always_comb begin
        sb_vld_s = {STAGES{1'b0}};
        sb_we_s  = {STAGES{1'b0}};
        sb_ld_s  = {STAGES{1'b0}};
        sb_rd_s  = {(STAGES*RD_MAX_W){1'b0}};
        for (int k = 1; k <= STAGES; k++) begin
            sb_vld_s[k-1]                         = sb_r[k].vld;
            sb_we_s[k-1]                          = sb_r[k].we;
            sb_ld_s[k-1]                          = sb_r[k].ld;
            sb_rd_s[(k-1)*RD_MAX_W +: RD_MAX_W]   = sb_r[k].rd;
        end
    end

    hazard_sel_enc #(
        .STAGES    (STAGES),
        .LOAD_SLOT (LOAD_SLOT),
        .SEL_W     (SEL_W)
    ) u_enc_a (
        .src         (RD_MAX_W'(id_rs1)),
        .use_src     (id_use_rs1),
        .vld         (sb_vld_s),
        .we          (sb_we_s),
        .ld          (sb_ld_s),
        .rd          (sb_rd_s),
        .sel         (sel_a_s),
        .load_hazard (haz_a_s)
    );

    hazard_sel_enc #(
        .STAGES    (STAGES),
        .LOAD_SLOT (LOAD_SLOT),
        .SEL_W     (SEL_W)
    ) u_enc_b (
        .src         (RD_MAX_W'(id_rs2)),
        .use_src     (id_use_rs2),
        .vld         (sb_vld_s),
        .we          (sb_we_s),
        .ld          (sb_ld_s),
        .rd          (sb_rd_s),
        .sel         (sel_b_s),
        .load_hazard (haz_b_s)
    );

    // Flush outranks stall; both vanish while reset is held.
    always_comb begin
        flush_s = rst & ex_branch_taken;
        stall_s = rst & id_valid & ~flush_s & (haz_a_s | haz_b_s);
    end

    // Every output reads as zero while reset is asserted.
    always_comb begin
        if (rst) begin
            stall     = stall_s;
            flush     = flush_s;
            fwd_a_sel = sel_a_s;
            fwd_b_sel = sel_b_s;
            stall_cnt = stall_cnt_r;
            flush_cnt = flush_cnt_r;
        end else begin
            stall     = 1'b0;
            flush     = 1'b0;
            fwd_a_sel = SEL_W'(FWD_RF);
            fwd_b_sel = SEL_W'(FWD_RF);
            stall_cnt = {CNT_W{1'b0}};
            flush_cnt = {CNT_W{1'b0}};
        end
    end

    // Scoreboard shift: slot STAGES retires, slot 1 takes decode or a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                sb_r[k] <= '{vld: 1'b0, rd: {RD_MAX_W{1'b0}}, we: 1'b0, ld: 1'b0};
            end
        end else begin
            for (int k = 2; k <= STAGES; k++) begin
                sb_r[k] <= sb_r[k-1];
            end
            if (stall_s || flush_s) begin
                sb_r[1] <= '{vld: 1'b0, rd: {RD_MAX_W{1'b0}}, we: 1'b0, ld: 1'b0};
            end else begin
                sb_r[1] <= '{vld: id_valid,
                             rd:  RD_MAX_W'(id_rd),
                             we:  id_regwrite & id_valid,
                             ld:  id_isload};
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios followed by random traffic,
// all compared against an instruction-history model of the in-flight window.
module tb_pipe_hazard_unit;

    localparam int REG_AW    = 5;
    localparam int STAGES    = 3;
    localparam int LOAD_SLOT = 2;
    localparam int CNT_W     = 2;
    localparam int SEL_W     = $clog2(STAGES + 1);
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_isload;
    logic              ex_branch_taken;
    logic              stall;
    logic              flush;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_unit #(
        .REG_AW    (REG_AW),
        .STAGES    (STAGES),
        .LOAD_SLOT (LOAD_SLOT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_isload       (id_isload),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush           (flush),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // One issued instruction as seen by later decodes; q[0] is the most recent issue.
    typedef struct {
        bit vld;
        int rd;
        bit we;
        bit ld;
    } instr_t;

    instr_t q[$];
    int     m_stall_cnt;
    int     m_flush_cnt;
    int     n_checks = 0;
    int     n_errors = 0;

    function automatic bool_match(instr_t e, int src);
        return e.vld && e.we && (e.rd == src) && (src != 0);
    endfunction

    function automatic int exp_sel(int src, bit use_src);
        if (!rst || !use_src) return 0;
        for (int age = 1; age <= STAGES; age++) begin
            if (bool_match(q[age-1], src) && (!q[age-1].ld || age >= LOAD_SLOT)) return age;
        end
        return 0;
    endfunction

    function automatic bit load_too_young(int src, bit use_src);
        if (!use_src) return 1'b0;
        for (int age = 1; age < LOAD_SLOT; age++) begin
            if (bool_match(q[age-1], src) && q[age-1].ld) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_flush();
        return rst && ex_branch_taken;
    endfunction

    function automatic bit exp_stall();
        return rst && id_valid && !exp_flush()
            && (load_too_young(int'(id_rs1), id_use_rs1) || load_too_young(int'(id_rs2), id_use_rs2));
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("stall",     32'(stall),     32'(exp_stall()));
        check("flush",     32'(flush),     32'(exp_flush()));
        check("fwd_a_sel", 32'(fwd_a_sel), exp_sel(int'(id_rs1), id_use_rs1));
        check("fwd_b_sel", 32'(fwd_b_sel), exp_sel(int'(id_rs2), id_use_rs2));
        check("stall_cnt", 32'(stall_cnt), rst ? m_stall_cnt : 0);
        check("flush_cnt", 32'(flush_cnt), rst ? m_flush_cnt : 0);
    endtask

    task automatic clear_model();
        instr_t b = '{vld: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        q.delete();
        for (int i = 0; i < STAGES; i++) q.push_back(b);
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Advance one clock and let the model follow the same edge.
    task automatic tick();
        bit     s   = exp_stall();
        bit     f   = exp_flush();
        bit     r   = rst;
        instr_t e;
        e.vld = id_valid && !s && !f;
        e.we  = id_regwrite && id_valid && !s && !f;
        e.rd  = int'(id_rd);
        e.ld  = id_isload && !s && !f;
        @(posedge clk);
        if (!r) begin
            clear_model();
        end else begin
            if (s && m_stall_cnt < CMAX) m_stall_cnt++;
            if (f && m_flush_cnt < CMAX) m_flush_cnt++;
            q.push_front(e);
            void'(q.pop_back());
        end
        #1;
    endtask

    task automatic set_id(bit v, int r1, bit u1, int r2, bit u2, int rd, bit rw, bit ld, bit br);
        id_valid        = v;
        id_rs1          = REG_AW'(r1);
        id_use_rs1      = u1;
        id_rs2          = REG_AW'(r2);
        id_use_rs2      = u2;
        id_rd           = REG_AW'(rd);
        id_regwrite     = rw;
        id_isload       = ld;
        ex_branch_taken = br;
        #2;
    endtask

    initial begin
        rst = 1'b0;
        clear_model();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all();
        check("reset_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b1;

        // Back-to-back ALU dependency
        set_id(1, 1, 1, 2, 1, 5, 1, 0, 0); check_all(); tick();
        set_id(1, 5, 1, 0, 0, 6, 1, 0, 0); check_all();
        check("alu_fwd_slot1", 32'(fwd_a_sel), 32'd1);
        check("alu_no_stall", 32'(stall), 32'd0);
        tick();
        set_id(1, 5, 1, 0, 0, 0, 0, 0, 0); check_all();
        check("alu_fwd_slot2", 32'(fwd_a_sel), 32'd2);
        tick();

        // Load-use: one stall then forward from LOAD_SLOT
        set_id(1, 0, 0, 0, 0, 7, 1, 1, 0); check_all(); tick();
        set_id(1, 0, 0, 7, 1, 11, 1, 0, 0); check_all();
        check("ld_use_stall", 32'(stall), 32'd1);
        tick();
        set_id(1, 0, 0, 7, 1, 11, 1, 0, 0); check_all();
        check("ld_use_released", 32'(stall), 32'd0);
        check("ld_use_fwd", 32'(fwd_b_sel), 32'd2);
        check("ld_use_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Youngest wins; x0 never forwards
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); check_all(); tick();
        set_id(1, 0, 0, 0, 0, 9, 1, 0, 0); check_all(); tick();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); check_all(); tick();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 0); check_all();
        check("youngest_wins", 32'(fwd_a_sel), 32'd1);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); check_all(); tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 0); check_all();
        check("x0_no_fwd", 32'(fwd_a_sel), 32'd0);
        tick();

        // Branch taken alongside a load-use hazard
        set_id(1, 0, 0, 0, 0, 8, 1, 1, 0); check_all(); tick();
        set_id(1, 8, 1, 0, 0, 12, 1, 0, 1); check_all();
        check("br_flush", 32'(flush), 32'd1);
        check("br_no_stall", 32'(stall), 32'd0);
        tick();
        set_id(1, 8, 1, 12, 1, 0, 0, 0, 0); check_all();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd1);
        check("br_bubble", 32'(fwd_b_sel), 32'd0);
        check("br_load_fwd", 32'(fwd_a_sel), 32'd2);
        tick();

        // Flush counter saturation
        for (int i = 0; i < 5; i++) begin
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 1); check_all(); tick();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); check_all();
        check("flush_sat", 32'(flush_cnt), 32'd3);
        tick();

        // Reset in the middle of a load-use stall
        set_id(1, 0, 0, 0, 0, 10, 1, 1, 0); check_all(); tick();
        rst = 1'b0;
        set_id(1, 10, 1, 0, 0, 13, 1, 0, 0); check_all();
        check("rst_forces_stall0", 32'(stall), 32'd0);
        tick();
        rst = 1'b1;
        set_id(1, 10, 1, 0, 0, 13, 1, 0, 0); check_all();
        check("rst_no_fwd", 32'(fwd_a_sel), 32'd0);
        check("rst_no_stall", 32'(stall), 32'd0);
        check("rst_cnt", 32'(flush_cnt), 32'd0);
        tick();

        // Random traffic over a small register range to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(99) != 0);
            set_id($urandom_range(3) != 0,
                   $urandom_range(7), $urandom_range(1),
                   $urandom_range(7), $urandom_range(1),
                   $urandom_range(7), $urandom_range(3) != 0,
                   $urandom_range(2) == 0, $urandom_range(9) == 0);
            check_all();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard controller for the in-order RISC pipeline. It sits beside the decode stage and keeps a scoreboard of the destination registers of in-flight instructions. From that scoreboard it produces three things: operand-forwarding selects, a load-use stall, and a taken-branch flush. It also keeps saturating event counters. It replaces the fixed, flush-only control of the first-generation top level and adds forwarding, stalling, configurable depth and performance counters.

## Interface
Parameters:
- REG_AW, 5, register-index width.
- STAGES, 3, in-flight slots tracked after decode (slot 1 = EX, slot STAGES = writeback). Legal range 2..7.
- LOAD_SLOT, 2, first slot in which load data may be forwarded. Legal range 2..STAGES.
- CNT_W, 16, event-counter width.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset, synchronous, active-low.
- id_valid, in, 1, the decode stage holds a real instruction.
- id_rs1 / id_rs2, in, REG_AW, source indices.
- id_use_rs1 / id_use_rs2, in, 1, the source is actually read.
- id_rd, in, REG_AW, destination index.
- id_regwrite, in, 1, the instruction writes the register file.
- id_isload, in, 1, the instruction is a load.
- ex_branch_taken, in, 1, the branch in slot 1 resolved taken this cycle.
- stall, out, 1, hold PC and IF/ID; insert a bubble into ID/EX.
- flush, out, 1, kill IF/ID and insert a bubble into ID/EX.
- fwd_a_sel / fwd_b_sel, out, $clog2(STAGES+1), 0 = register file, k = result of slot k.
- stall_cnt / flush_cnt, out, CNT_W, saturating event counts.

## Operation
- Scoreboard: per slot k = 1..STAGES, the fields vld, rd, we and ld. An entry "matches" source r when vld && we && rd == r && r != 0.
- Forwarding: fwd_x_sel = the smallest k whose entry matches the used source. A load entry counts only if k >= LOAD_SLOT. If nothing qualifies, the select is 0. When the source is unused, the select is 0.
- Load-use stall: stall = id_valid && !flush && (some used source matches a load entry in a slot k < LOAD_SLOT).
- Flush: flush = ex_branch_taken. Flush has priority over stall, so stall is 0 whenever flush is 1.
- Scoreboard update at each edge:
  - Slots shift, k → k+1. Slot STAGES retires.
  - Slot 1 loads the decode instruction (vld = id_valid, we = id_regwrite && id_valid, ld = id_isload).
  - When stall or flush is active, slot 1 loads a bubble instead (vld = 0, we = 0).
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with flush = 1.
  - Both saturate at all-ones and never wrap.
- Index 0 never matches, so it never forwards and never stalls.

## Timing
- stall, flush and fwd_*_sel are combinational from the inputs and scoreboard state, with zero-cycle latency. The scoreboard and counters update on the rising edge.
- A load in slot 1 forces exactly LOAD_SLOT−1 stall cycles on a dependent instruction. After those cycles the load has moved to slot LOAD_SLOT and is forwarded with sel = LOAD_SLOT.
- Reset (rst = 0 at an edge):
  - All vld/we/ld bits and both counters clear.
  - While rst = 0, every output is forced to 0: stall, flush, fwd selects and counters.
  - Reset in mid-stall or mid-flush aborts the stall or flush immediately. There is no residual state.
- When flush and a load-use hazard occur in the same cycle, flush wins and stall_cnt does not increment.
- With id_valid = 0, stall is 0 and a bubble enters slot 1.
- When several slots match, the youngest (lowest k) wins.

## Structure
- Shared package pipe_pkg holds:
  - typedef sb_entry_t {vld, rd, we, ld}.
  - The FWD_RF = 0 constant.
  - The $clog2-derived select width, as a function of STAGES.
- One sub-module, hazard_sel_enc: a parametrised priority encoder that returns the first matching slot for one source operand. It is instantiated twice, once for rs1 and once for rs2.
- The scoreboard shift register and the counters live in the top module.

## Test plan
- Back-to-back ALU dependency: add x5 followed by sub using rs1 = x5 → fwd_a_sel = 1, stall = 0. One instruction later, the same source gives fwd_a_sel = 2.
- Load-use (LOAD_SLOT = 2): lw x7 followed by add using rs2 = x7 → stall = 1 for exactly one cycle, then fwd_b_sel = 2. Afterwards stall_cnt = 1.
- Youngest wins: x3 is written in slots 1 and 3 → sel = 1. A write to x0 in slot 1 → sel = 0.
- Branch taken while a load-use hazard is present → flush = 1, stall = 0, slot 1 becomes a bubble, flush_cnt = 1, stall_cnt unchanged.
- Counter saturation with CNT_W = 2: five flushes → flush_cnt = 3.
- Reset mid-stall: rst = 0 for one edge → all outputs are 0 after the edge. The previously pending dependency no longer forwards or stalls.
